// File: rtl/alu_stage_pkg.sv
// Shared op codes, flag bit positions and the buffered entry type for the ALU result stage.
package alu_stage_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Entries carry the widest supported datapath; narrower stages zero-extend into it.
    localparam int ENTRY_MAX_W = 64;

    typedef struct packed {
        logic [ENTRY_MAX_W-1:0] result;
        logic [3:0]             rd;
    } entry_t;

endpackage

// File: rtl/flag_unit.sv
// Combinational next-NZCV computation; C and V are only touched by arithmetic ops.
module flag_unit
    import alu_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] result,
    input  logic         carry_out,
    input  logic         msb_sum,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [3:0]   op,
    input  logic [3:0]   flags_cur,
    output logic [3:0]   flags_next
);

    always_comb begin
        flags_next         = flags_cur;
        flags_next[FLAG_N] = result[N-1];
        flags_next[FLAG_Z] = (result == '0);
        if (!op[3]) begin
            flags_next[FLAG_C] = carry_out;
            case (op)
                OP_ADD:  flags_next[FLAG_V] = (a_msb == b_msb) && (msb_sum != a_msb);
                OP_SUB:  flags_next[FLAG_V] = (a_msb != b_msb) && (msb_sum != a_msb);
                default: flags_next[FLAG_V] = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// Two-entry skid buffer between the ALU and writeback, plus the architectural NZCV register.
module alu_result_stage
    import alu_stage_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] result,
    input  logic         carry_out,
    input  logic         msb_sum,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic [3:0]   op,
    input  logic         set_flags,
    input  logic [3:0]   rd,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_result,
    output logic [3:0]   out_rd,
    output logic [3:0]   flags
);

    logic       main_valid_reg, main_valid_next;
    logic       skid_valid_reg, skid_valid_next;
    entry_t     main_reg, main_next;
    entry_t     skid_reg, skid_next;
    logic [3:0] flags_reg, flags_next;
    logic [3:0] flag_unit_out;
    entry_t     in_entry;
    logic       accept;
    logic       issue;

    // in_ready depends only on registered state, so out_ready never reaches it combinationally.
    assign in_ready   = !skid_valid_reg;
    assign out_valid  = main_valid_reg;
    assign out_result = main_reg.result[N-1:0];
    assign out_rd     = main_reg.rd;
    assign flags      = flags_reg;

    assign accept = in_valid && in_ready && !flush;
    assign issue  = main_valid_reg && out_ready;

    assign in_entry.result = ENTRY_MAX_W'(result);
    assign in_entry.rd     = rd;

    flag_unit #(.N(N)) u_flag_unit (
        .result     (result),
        .carry_out  (carry_out),
        .msb_sum    (msb_sum),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .op         (op),
        .flags_cur  (flags_reg),
        .flags_next (flag_unit_out)
    );

    always_comb begin
        main_valid_next = main_valid_reg;
        skid_valid_next = skid_valid_reg;
        main_next       = main_reg;
        skid_next       = skid_reg;
        flags_next      = flags_reg;
        if (flush) begin
            main_valid_next = 1'b0;
            skid_valid_next = 1'b0;
        end else begin
            if (issue) begin
                if (skid_valid_reg) begin
                    main_next       = skid_reg;
                    skid_valid_next = 1'b0;
                end else begin
                    main_valid_next = accept;
                    if (accept) begin
                        main_next = in_entry;
                    end
                end
            end else if (accept) begin
                if (!main_valid_reg) begin
                    main_valid_next = 1'b1;
                    main_next       = in_entry;
                end else begin
                    skid_valid_next = 1'b1;
                    skid_next       = in_entry;
                end
            end
            if (accept && set_flags) begin
                flags_next = flag_unit_out;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
            main_reg       <= '0;
            skid_reg       <= '0;
            flags_reg      <= '0;
        end else begin
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            flags_reg      <= flags_next;
        end
    end

    // Padding above the datapath width must never pick up data.
    generate
        if (N < ENTRY_MAX_W) begin : g_pad_check
            always_comb begin
                assert (!rst_n || ((main_reg.result[ENTRY_MAX_W-1:N] == '0) &&
                                   (skid_reg.result[ENTRY_MAX_W-1:N] == '0)));
            end
        end
    endgenerate

endmodule

// File: tb/tb_alu_result_stage.sv
// Randomised and directed checks of alu_result_stage against a queue-based reference model.
module tb_alu_result_stage;
    import alu_stage_pkg::*;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] result = '0;
    logic         carry_out = 1'b0;
    logic         msb_sum = 1'b0;
    logic         a_msb = 1'b0;
    logic         b_msb = 1'b0;
    logic [3:0]   op = 4'h0;
    logic         set_flags = 1'b0;
    logic [3:0]   rd = 4'h0;
    logic         flush = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] out_result;
    logic [3:0]   out_rd;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    alu_result_stage #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result     (result),
        .carry_out  (carry_out),
        .msb_sum    (msb_sum),
        .a_msb      (a_msb),
        .b_msb      (b_msb),
        .op         (op),
        .set_flags  (set_flags),
        .rd         (rd),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .flags      (flags)
    );

    int tests_run = 0;
    int tests_failed = 0;

    typedef struct {
        logic [N-1:0] res;
        logic [3:0]   rd;
    } exp_t;

    exp_t       m_q[$];
    logic [3:0] m_flags = 4'h0;
    int         cur_a = 0;
    int         cur_b = 0;

    // Drives one ALU result; ADD/SUB derive adder signals from real operands.
    task automatic drive_op(input logic [3:0] o, input logic [N-1:0] a, input logic [N-1:0] b,
                            input logic [3:0] r, input logic sf);
        logic [N:0] s;
        op = o; rd = r; set_flags = sf; in_valid = 1'b1;
        a_msb = a[N-1]; b_msb = b[N-1];
        cur_a = $signed(a);
        cur_b = $signed(b);
        if (o == OP_ADD || o == OP_SUB) begin
            if (o == OP_SUB) s = {1'b0, a} + {1'b0, ~b} + (N+1)'(1);
            else             s = {1'b0, a} + {1'b0, b};
            result = s[N-1:0]; carry_out = s[N]; msb_sum = s[N-1];
        end else begin
            result = a; carry_out = 1'($urandom); msb_sum = 1'($urandom);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0; set_flags = 1'b0; flush = 1'b0;
    endtask

    // Flags from the arithmetic meaning of the operation (signed range overflow).
    function automatic logic [3:0] ref_flags(input logic [3:0] cur);
        logic [3:0] f;
        int lo, hi, r;
        lo = -(1 << (N-1));
        hi = (1 << (N-1)) - 1;
        f = cur;
        f[3] = result[N-1];
        f[2] = (result == '0);
        if (!op[3]) begin
            f[1] = carry_out;
            if (op == OP_ADD) begin
                r = cur_a + cur_b; f[0] = (r < lo) || (r > hi);
            end else if (op == OP_SUB) begin
                r = cur_a - cur_b; f[0] = (r < lo) || (r > hi);
            end else begin
                f[0] = 1'b0;
            end
        end
        return f;
    endfunction

    // Advance the model by one clock using the currently driven inputs, then clock the DUT.
    task automatic step();
        bit   acc, iss;
        exp_t e;
        acc = in_valid && (m_q.size() < 2) && !flush;
        iss = (m_q.size() > 0) && out_ready;
        if (flush) begin
            m_q.delete();
        end else begin
            if (iss) void'(m_q.pop_front());
            if (acc) begin
                e.res = result; e.rd = rd;
                m_q.push_back(e);
                if (set_flags) m_flags = ref_flags(m_flags);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_handshake: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        tests_run++;
        if (flags !== 4'h0 || out_result !== '0 || out_rd !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_data: flags=%b out_result=%h out_rd=%h, required 0", flags, out_result, out_rd);
        end
        #1 rst_n = 1'b1;
        drive_op(OP_ADD, 4'd3, 4'd4, 4'h5, 1'b0);
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 4'd7 || out_rd !== 4'h5) begin
            tests_failed++;
            $display("FAIL first_accept: valid=%b result=%h rd=%h, required 1/7/5", out_valid, out_result, out_rd);
        end
        idle(); out_ready = 1'b1;
        step();
    endtask

    task automatic test_flags_directed();
        out_ready = 1'b1;
        drive_op(OP_ADD, 4'b1000, 4'b1000, 4'h1, 1'b1);
        step();
        tests_run++;
        if (flags !== 4'b0111) begin
            tests_failed++;
            $display("FAIL add_overflow_flags: got %b, required 0111", flags);
        end
        drive_op(OP_SUB, 4'b0111, 4'b1000, 4'h2, 1'b1);
        step();
        tests_run++;
        if (flags !== 4'b1001) begin
            tests_failed++;
            $display("FAIL sub_overflow_flags: got %b, required 1001", flags);
        end
        drive_op(OP_ADD, 4'b1000, 4'b1001, 4'h3, 1'b1);
        step();
        tests_run++;
        if (flags !== 4'b0011) begin
            tests_failed++;
            $display("FAIL add_cv_flags: got %b, required 0011", flags);
        end
        drive_op(4'b1000, 4'b0000, 4'b0000, 4'h4, 1'b1);
        step();
        tests_run++;
        if (flags !== 4'b0111) begin
            tests_failed++;
            $display("FAIL logic_keeps_cv: got %b, required 0111", flags);
        end
        drive_op(OP_ADD, 4'b0001, 4'b0001, 4'h5, 1'b0);
        step();
        tests_run++;
        if (flags !== 4'b0111) begin
            tests_failed++;
            $display("FAIL no_set_flags: got %b, required 0111", flags);
        end
        idle();
        step();
    endtask

    task automatic test_backpressure();
        idle(); out_ready = 1'b0;
        drive_op(OP_ADD, 4'd1, 4'd2, 4'hA, 1'b0);
        step();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_result !== 4'd3) begin
            tests_failed++;
            $display("FAIL bp_first: in_ready=%b valid=%b result=%h, required 1/1/3", in_ready, out_valid, out_result);
        end
        drive_op(OP_ADD, 4'd5, 4'd1, 4'hB, 1'b0);
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_result !== 4'd3 || out_rd !== 4'hA) begin
            tests_failed++;
            $display("FAIL bp_second: in_ready=%b result=%h rd=%h, required 0/3/a", in_ready, out_result, out_rd);
        end
        drive_op(OP_ADD, 4'd2, 4'd2, 4'hC, 1'b0);
        step();
        tests_run++;
        if (in_ready !== 1'b0 || out_rd !== 4'hA) begin
            tests_failed++;
            $display("FAIL bp_third_refused: in_ready=%b rd=%h, required 0/a", in_ready, out_rd);
        end
        idle(); out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_rd !== 4'hB || out_result !== 4'd6 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_drain_b: valid=%b rd=%h result=%h in_ready=%b, required 1/b/6/1",
                     out_valid, out_rd, out_result, in_ready);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_empty: out_valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_op(OP_ADD, 4'(i), 4'd1, 4'(i), 1'b0);
            step();
            tests_run++;
            if (out_valid !== 1'b1 || out_rd !== 4'(i) || out_result !== 4'(i + 1) || in_ready !== 1'b1) begin
                tests_failed++;
                $display("FAIL back_to_back[%0d]: valid=%b rd=%h result=%h in_ready=%b, required 1/%h/%h/1",
                         i, out_valid, out_rd, out_result, in_ready, 4'(i), 4'(i + 1));
            end
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        logic [3:0] saved;
        idle(); out_ready = 1'b0;
        drive_op(OP_ADD, 4'd2, 4'd3, 4'h6, 1'b0);
        step();
        saved = m_flags;
        drive_op(OP_ADD, 4'b1000, 4'b1000, 4'h7, 1'b1);
        flush = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || flags !== saved) begin
            tests_failed++;
            $display("FAIL flush_accept: valid=%b in_ready=%b flags=%b, required 0/1/%b",
                     out_valid, in_ready, flags, saved);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        logic [3:0] o;
        for (int i = 0; i < 400; i++) begin
            tests_run++;
            if (out_valid !== (m_q.size() > 0) || in_ready !== (m_q.size() < 2) || flags !== m_flags) begin
                tests_failed++;
                $display("FAIL random_ctrl[%0d]: valid=%b in_ready=%b flags=%b, required %b/%b/%b", i,
                         out_valid, in_ready, flags, m_q.size() > 0, m_q.size() < 2, m_flags);
            end
            if (m_q.size() > 0) begin
                tests_run++;
                if (out_result !== m_q[0].res || out_rd !== m_q[0].rd) begin
                    tests_failed++;
                    $display("FAIL random_data[%0d]: result=%h rd=%h, required %h/%h", i,
                             out_result, out_rd, m_q[0].res, m_q[0].rd);
                end
            end
            case ($urandom_range(0, 3))
                0:       o = OP_ADD;
                1:       o = OP_SUB;
                default: o = 4'($urandom);
            endcase
            drive_op(o, N'($urandom), N'($urandom), 4'($urandom), 1'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        idle();
    endtask

    task automatic test_async_reset();
        idle(); out_ready = 1'b0;
        drive_op(OP_ADD, 4'b1000, 4'b1000, 4'h8, 1'b1);
        step();
        drive_op(OP_SUB, 4'b0111, 4'b1000, 4'h9, 1'b1);
        step();
        idle();
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL pre_reset_full: valid=%b in_ready=%b, required 1/0", out_valid, in_ready);
        end
        #3 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || flags !== 4'h0 || in_ready !== 1'b1 || out_result !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: valid=%b flags=%b in_ready=%b result=%h, required 0/0000/1/0",
                     out_valid, flags, in_ready, out_result);
        end
        m_q.delete();
        m_flags = 4'h0;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        tests_run++;
        if (out_valid !== 1'b0 || flags !== 4'h0) begin
            tests_failed++;
            $display("FAIL post_reset_no_issue: valid=%b flags=%b, required 0/0000", out_valid, flags);
        end
    endtask

    initial begin
        test_reset();
        test_flags_directed();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
